// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, 16x oversampling, 8N1 LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit and a parity_err pulse output.
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [1:0]    sync_reg;
  logic          rx_s;
  logic [CW-1:0] div_cnt_reg;
  logic          tick;
  logic          start_det;
  logic          bit_end;

  logic [2:0] state_reg, state_next;
  logic       armed_reg, armed_next;
  logic [3:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shifter_reg, shifter_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rxrdy_reg, rxrdy_next;
  logic       frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic       par_bit_reg, par_bit_next;
  logic       parity_err_reg, parity_err_next;
`endif

  assign rx_s      = sync_reg[1];
  assign tick      = (div_cnt_reg == DIV_LAST);
  assign start_det = (state_reg == IDLE) && armed_reg && !rx_s;
  // START samples mid-bit after 8 ticks; every later sample is a full bit (16 ticks) on.
  assign bit_end   = tick && (tick_cnt_reg == ((state_reg == START) ? 4'd7 : 4'd15));

  always_comb begin
    state_next      = state_reg;
    armed_next      = armed_reg;
    tick_cnt_next   = tick_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shifter_next    = shifter_reg;
    rx_data_next    = rx_data_reg;
    rxrdy_next      = 1'b0;
    frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next    = par_bit_reg;
    parity_err_next = 1'b0;
`endif
    if (state_reg != IDLE && tick)
      tick_cnt_next = bit_end ? 4'd0 : 4'(tick_cnt_reg + 4'd1);

    case (state_reg)
      IDLE: begin
        if (!armed_reg) begin
          if (rx_s) armed_next = 1'b1;
        end else if (!rx_s) begin
          state_next    = START;
          tick_cnt_next = 4'd0;
          bit_cnt_next  = 3'd0;
        end
      end
      START: begin
        if (bit_end) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shifter_next = {rx_s, shifter_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
`else
          if (bit_cnt_reg == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          par_bit_next = rx_s;
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Leave unarmed so a held-low break cannot retrigger a frame.
          state_next = IDLE;
          armed_next = 1'b0;
          if (!rx_s) begin
            frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if ((^shifter_reg) ^ par_bit_reg) begin
            parity_err_next = 1'b1;
`endif
          end else begin
            rx_data_next = shifter_reg;
            rxrdy_next   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg       <= 2'b11;
      div_cnt_reg    <= '0;
      state_reg      <= IDLE;
      armed_reg      <= 1'b0;
      tick_cnt_reg   <= 4'd0;
      bit_cnt_reg    <= 3'd0;
      shifter_reg    <= 8'h00;
      rx_data_reg    <= 8'h00;
      rxrdy_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      sync_reg       <= {sync_reg[0], rx};
      div_cnt_reg    <= (start_det || tick) ? '0 : CW'(div_cnt_reg + 1'b1);
      state_reg      <= state_next;
      armed_reg      <= armed_next;
      tick_cnt_reg   <= tick_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shifter_reg    <= shifter_next;
      rx_data_reg    <= rx_data_next;
      rxrdy_reg      <= rxrdy_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= par_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign rx_data    = rx_data_reg;
  assign rxrdy      = rxrdy_reg;
  assign frame_err  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`endif
  assign busy       = (state_reg != IDLE);

endmodule
